// File: rtl/demux_1_2_stream.sv
// demux_1_2_stream: registered 1-to-2 stream demux with per-channel output registers and accept counters
module demux_1_2_stream #(
  parameter int WIDTH   = 64,
  parameter int COUNT_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sel,
  input  logic [WIDTH-1:0]              in_data,
  output logic [1:0]                    out_valid,
  input  logic [1:0]                    out_ready,
  output logic [1:0][WIDTH-1:0]         out_data,
  output logic [1:0][COUNT_W-1:0]       out_count
);
  logic [1:0] load;
  // only the selected channel can stall the input; a draining channel accepts in the same cycle
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign load     = {in_valid & in_ready & in_sel, in_valid & in_ready & ~in_sel};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= '0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (load[i]) begin
          out_valid[i] <= 1'b1;
          out_data[i]  <= in_data;
          out_count[i] <= out_count[i] + COUNT_W'(1);
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_demux_1_2_stream.sv
// tb_demux_1_2_stream: randomized and directed checks against a per-channel scoreboard model
module tb_demux_1_2_stream;
  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              in_sel;
  logic [63:0]       in_data;
  logic [1:0]        out_valid;
  logic [1:0]        out_ready;
  logic [1:0][63:0]  out_data;
  logic [1:0][7:0]   out_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] held [2][$];
  logic [63:0] last [2];
  int          cnt  [2];

  demux_1_2_stream #(.WIDTH(64), .COUNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      held[c].delete();
      last[c] = '0;
      cnt[c]  = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data0", out_data[0], 64'd0);
    chk("rst_data1", out_data[1], 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    model_clear();
    #2;
    reset = 1'b0;
  endtask

  // one clock: drive at negedge, check against the model, advance the model at posedge
  task automatic cycle(input logic v, input logic s, input logic [63:0] d, input logic [1:0] r,
                       output logic acc);
    logic exp_rdy;
    @(negedge clk);
    in_valid = v; in_sel = s; in_data = d; out_ready = r;
    #1;
    exp_rdy = (held[s].size() == 0) || r[s];
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("valid%0d", c), 64'(out_valid[c]), 64'(held[c].size() != 0));
      chk($sformatf("data%0d", c), out_data[c], held[c].size() != 0 ? held[c][0] : last[c]);
      chk($sformatf("count%0d", c), 64'(out_count[c]), 64'(cnt[c]));
    end
    @(posedge clk);
    for (int c = 0; c < 2; c++)
      if (held[c].size() != 0 && r[c]) void'(held[c].pop_front());
    acc = v && exp_rdy;
    if (acc) begin
      held[s].push_back(d);
      last[s] = d;
      cnt[s]  = (cnt[s] + 1) % 256;
    end
    chk("depth", 64'(held[s].size() > 1), 64'd0);
  endtask

  initial begin
    logic        a, v, s, pv, pacc;
    logic [63:0] d;
    logic [7:0]  c1_before;
    reset = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0; out_ready = 2'b00;
    model_clear();
    do_reset();

    cycle(1'b1, 1'b0, 64'hA5, 2'b11, a);
    #1;
    chk("route0_valid", 64'(out_valid), 64'd1);
    chk("route0_data", out_data[0], 64'hA5);
    chk("route0_count", 64'(out_count[0]), 64'd1);
    cycle(1'b1, 1'b1, 64'h3C, 2'b11, a);
    #1;
    chk("route1_valid", 64'(out_valid), 64'd2);
    chk("route1_data", out_data[1], 64'h3C);
    chk("route1_count", 64'(out_count[1]), 64'd1);
    cycle(1'b0, 1'b0, 64'h0, 2'b11, a);

    cycle(1'b1, 1'b0, 64'h11, 2'b00, a);
    cycle(1'b1, 1'b0, 64'h22, 2'b00, a);
    chk("bp_second_blocked", 64'(a), 64'd0);
    #1;
    chk("bp_held", out_data[0], 64'h11);
    cycle(1'b1, 1'b0, 64'h22, 2'b01, a);
    chk("bp_load_on_drain", 64'(a), 64'd1);
    #1;
    chk("bp_no_bubble", 64'(out_valid[0]), 64'd1);
    chk("bp_new_data", out_data[0], 64'h22);

    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 1'b1, 64'(i), 2'b10, a);
      chk("indep_accept", 64'(a), 64'd1);
    end
    #1;
    chk("indep_ch0_data", out_data[0], 64'h22);
    chk("indep_ch1_data", out_data[1], 64'd5);

    c1_before = out_count[1];
    for (int i = 0; i < 256; i++) cycle(1'b1, 1'b1, {$urandom, $urandom}, 2'b10, a);
    #1;
    chk("wrap_count1", 64'(out_count[1]), 64'(c1_before));
    chk("wrap_count0", 64'(out_count[0]), 64'(cnt[0]));

    cycle(1'b1, 1'b0, 64'hDEAD, 2'b00, a);
    cycle(1'b1, 1'b1, 64'hBEEF, 2'b00, a);
    cycle(1'b0, 1'b0, 64'h0, 2'b00, a);
    do_reset();

    pv = 1'b0; pacc = 1'b0; v = 1'b0; s = 1'b0; d = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!(pv && !pacc)) begin
        v = ($urandom_range(3) != 0);
        s = 1'($urandom_range(1));
        d = {$urandom, $urandom};
      end
      cycle(v, s, d, 2'($urandom_range(3)), pacc);
      pv = v;
    end
    cycle(1'b0, 1'b0, 64'h0, 2'b11, a);
    cycle(1'b0, 1'b0, 64'h0, 2'b11, a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
